// File: rtl/uart_pkg.sv
// Shared UART constants and the arbiter state type.
package uart_pkg;

  localparam int UART_BYTE_W  = 8;
  localparam int DELAY_FRAMES = 234;  // serializer baud divider default

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANTED
  } arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set bit of req after last_grant,
// wrapping modulo NUM_REQ.
module uart_rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic                       any_valid
);

  localparam int GW = $clog2(NUM_REQ);

  int            idx;
  logic [GW-1:0] idx_w;

  // Scan farthest-first so the candidate right after last_grant is written last.
  always_comb begin
    winner    = '0;
    any_valid = |req;
    idx       = 0;
    idx_w     = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx   = (int'(last_grant) + i) % NUM_REQ;
      idx_w = GW'(idx);
      if (req[idx_w]) winner = idx_w;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte serializer between NUM_REQ sources.
// Optional stall timeout enabled by defining UART_ARB_TIMEOUT_EN.
//   state       | meaning
//   ARB_IDLE    | no grant held; picks next winner when any source is valid
//   ARB_GRANTED | grant_id owns the serializer until its last byte transfers
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [UART_BYTE_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           tx_valid,
  output logic [UART_BYTE_W-1:0]         tx_data,
  input  logic                           tx_ready,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           busy,
  output logic                           timeout_evt
);

  localparam int GW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("uart_tx_arbiter: NUM_REQ or TIMEOUT_CYCLES out of range");
  end

  arb_state_t             state, next_state;
  logic [GW-1:0]          last_grant, winner;
  logic                   any_valid, sel_valid, sel_last, xfer, release_g, timeout;
  logic [UART_BYTE_W-1:0] sel_data;
  logic [UART_BYTE_W-1:0] data_arr [NUM_REQ];

  uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req       (req_valid),
    .last_grant(last_grant),
    .winner    (winner),
    .any_valid (any_valid)
  );

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign data_arr[i] = req_data[i*UART_BYTE_W +: UART_BYTE_W];
  end

  assign sel_valid = req_valid[grant_id];
  assign sel_last  = req_last[grant_id];
  assign sel_data  = data_arr[grant_id];
  assign xfer      = (state == ARB_GRANTED) && sel_valid && tx_ready;
  assign release_g = (xfer && sel_last) || timeout;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] stall_cnt;

  // Expiry only while the owner is idle, so a byte in flight is never cut off.
  assign timeout = (state == ARB_GRANTED) && !sel_valid &&
                   (stall_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (state != ARB_GRANTED || sel_valid || timeout)
      stall_cnt <= '0;
    else
      stall_cnt <= stall_cnt + CW'(1);
  end
`else
  assign timeout = 1'b0;
`endif

  assign timeout_evt = timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARB_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ARB_IDLE:    if (any_valid) next_state = ARB_GRANTED;
      ARB_GRANTED: if (release_g) next_state = ARB_IDLE;
      default:     next_state = ARB_IDLE;
    endcase
  end

  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = '0;
    req_ready = '0;
    busy      = 1'b0;
    if (state == ARB_GRANTED) begin
      tx_valid            = sel_valid;
      tx_data             = sel_data;
      req_ready[grant_id] = tx_ready;
      busy                = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_id   <= '0;
      last_grant <= GW'(NUM_REQ - 1);
    end else begin
      if (state == ARB_IDLE && any_valid)
        grant_id <= winner;
      if (state == ARB_GRANTED && release_g)
        last_grant <= grant_id;
    end
  end

endmodule
